// File: rtl/startup_sequencer.sv
// Power-up sequencer: POR settle delay, then audio/video/engine bring-up
// with per-stage ready timeout, runtime health check and soft restart.
module startup_sequencer #(
  parameter int POR_CYCLES     = 4096,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       restart_i,
  input  logic [2:0] stage_ready_i,
  output logic [2:0] stage_en_o,
  output logic [2:0] stage_start_o,
  output logic       run_o,
  output logic       fault_o,
  output logic [1:0] fault_stage_o,
  output logic [2:0] state_dbg_o
);

  typedef enum logic [2:0] {
    POR   = 3'd0,
    STG0  = 3'd1,
    STG1  = 3'd2,
    STG2  = 3'd3,
    RUN   = 3'd4,
    FAULT = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       en_q, en_d;
  logic [2:0]       start_q, start_d;
  logic             run_q, run_d;
  logic             fault_q, fault_d;
  logic [1:0]       fs_q, fs_d;

  logic [2:0] done;
  logic [2:0] drop;
  logic [1:0] k;
  logic [2:0] sel;
  logic       flt;
  logic [1:0] flt_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    start_d = 3'b000;
    run_d   = run_q;
    fault_d = fault_q;
    fs_d    = fs_q;
    flt     = 1'b0;
    flt_idx = 2'd0;
    k       = state_q[1:0] - 2'd1;
    sel     = 3'b001 << k;

    // stages already brought up that must keep ready asserted
    unique case (state_q)
      STG1:    done = 3'b001;
      STG2:    done = 3'b011;
      RUN:     done = 3'b111;
      default: done = 3'b000;
    endcase
    drop = done & ~stage_ready_i;

    unique case (state_q)
      POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = STG0;
          cnt_d   = '0;
          en_d    = 3'b001;
          start_d = 3'b001;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STG0, STG1, STG2: begin
        if (|drop) begin
          flt     = 1'b1;
          flt_idx = drop[0] ? 2'd0 : (drop[1] ? 2'd1 : 2'd2);
        end else if (|(stage_ready_i & sel)) begin
          cnt_d = '0;
          if (state_q == STG2) begin
            state_d = RUN;
            run_d   = 1'b1;
            en_d    = 3'b111;
          end else begin
            state_d = state_e'(state_q + 3'd1);
            en_d    = en_q | (sel << 1);
            start_d = sel << 1;
          end
        end else if (cnt_q == TO_LAST) begin
          flt     = 1'b1;
          flt_idx = k;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (|drop) begin
          flt     = 1'b1;
          flt_idx = drop[0] ? 2'd0 : (drop[1] ? 2'd1 : 2'd2);
        end
      end
      default: ;
    endcase

    if (flt) begin
      state_d = FAULT;
      cnt_d   = '0;
      en_d    = 3'b000;
      start_d = 3'b000;
      run_d   = 1'b0;
      fault_d = 1'b1;
      fs_d    = flt_idx;
    end

    if (restart_i) begin
      state_d = POR;
      cnt_d   = '0;
      en_d    = 3'b000;
      start_d = 3'b000;
      run_d   = 1'b0;
      fault_d = 1'b0;
      fs_d    = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= POR;
      cnt_q   <= '0;
      en_q    <= 3'b000;
      start_q <= 3'b000;
      run_q   <= 1'b0;
      fault_q <= 1'b0;
      fs_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      start_q <= start_d;
      run_q   <= run_d;
      fault_q <= fault_d;
      fs_q    <= fs_d;
    end
  end

  assign stage_en_o    = en_q;
  assign stage_start_o = start_q;
  assign run_o         = run_q;
  assign fault_o       = fault_q;
  assign fault_stage_o = fs_q;
  assign state_dbg_o   = state_q;

endmodule

// File: doc/startup_sequencer.md
Name: startup_sequencer

Overview:
- Power-up and bring-up controller for the drum-game top level.
- Waits a fixed power-on settling delay, then enables three downstream subsystems in order: 0 = audio codec init, 1 = display/VGA, 2 = game engine.
- Each stage has a ready handshake and a timeout. The block reports run or fault to the top level and supports a soft restart.

Parameters:
- POR_CYCLES, 4096: cycles from reset release to the first stage enable; must be >= 2.
- TIMEOUT_CYCLES, 65535: maximum cycles a stage may take to report ready; must be >= 2.
- CNT_W, 16: shared counter width; must satisfy 2^CNT_W > max(POR_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset; one clock; reset is asynchronous and active-low.
- restart, in, 1: synchronous soft restart request, level-sensitive.
- stage_ready, in, 3: per-stage ready from subsystems; bit k belongs to stage k.
- stage_en, out, 3: per-stage enable, registered, sticky once set.
- stage_start, out, 3: one-cycle pulse on entry to stage k.
- run, out, 1: all stages up and healthy.
- fault, out, 1: sequencing failed.
- fault_stage, out, 2: index of the failing stage, valid while fault = 1.
- state_dbg, out, 3: current state encoding, for LEDs.

Behaviour:
- States and encodings: POR = 0, STG0 = 1, STG1 = 2, STG2 = 3, RUN = 4, FAULT = 5.
- Reset (rst_n low, asynchronous):
  - state = POR, counter = 0.
  - stage_en, stage_start, run, fault = 0; fault_stage = 0.
  - Takes effect immediately, including mid-sequence.
- Outputs: all registered, no combinational paths from inputs.
- POR:
  - Counter increments every cycle.
  - When counter == POR_CYCLES-1, go to STG0 and clear the counter.
  - The stage_en[0] rising edge occurs exactly POR_CYCLES clock edges after rst_n deasserts; the first edge with rst_n high counts as 1.
- STGk entry edge:
  - stage_en[k] <= 1; stage_start[k] = 1 for exactly one cycle; counter <= 0.
  - Lower enables stay high.
- STGk, each cycle:
  - stage_ready[k] is sampled, including the entry cycle.
  - If high, go to STG(k+1), or to RUN from STG2.
  - Otherwise, if counter == TIMEOUT_CYCLES-1, go to FAULT with fault_stage = k.
  - Otherwise the counter increments.
  - Ready and timeout in the same cycle: ready wins.
- Minimum stage time:
  - A stage whose ready is already high advances after 1 cycle.
  - Best-case POR-to-run latency is POR_CYCLES+3 edges.
- Health check in STGk and RUN:
  - Any completed stage j < k (all three in RUN) whose stage_ready[j] drops goes to FAULT.
  - fault_stage = lowest such j.
  - Stages not yet started are ignored.
- RUN: run = 1; stage_en = 3'b111.
- FAULT:
  - stage_en = 0 and run = 0 on the transition edge; fault = 1.
  - fault_stage is held.
  - Stays in FAULT until restart.
- restart, sampled high in any state:
  - Next state = POR, counter = 0.
  - stage_en, run, fault = 0; fault_stage = 0.
  - Highest priority over all other transitions.
  - Held high keeps the block in POR with the counter at 0; the delay starts on the first cycle restart is low.
- Counter: never wraps, because it is always cleared before reaching 2^CNT_W-1.
- stage_start: never more than one bit high; never high in POR, RUN or FAULT.

Test Plan:
(bench parameters: POR_CYCLES = 16, TIMEOUT_CYCLES = 8)
- Nominal bring-up:
  - Stimulus: release rst_n with stage_ready = 3'b111 throughout.
  - Response: stage_en[0] rises at edge 16, stage_en[1] at 17, stage_en[2] at 18; run = 1 at edge 19; stage_start pulses one cycle each; state_dbg steps 0 → 1 → 2 → 3 → 4.
- Timeout:
  - Stimulus: stage_ready[0] = 1, stage_ready[1] never asserts.
  - Response: FAULT exactly 8 cycles after entering STG1; fault = 1, fault_stage = 1, stage_en = 0, run = 0.
- Ready on last cycle:
  - Stimulus: stage_ready[2] rises on the 8th cycle of STG2.
  - Response: RUN, no fault (ready beats timeout).
- Runtime drop:
  - Stimulus: in RUN, drop stage_ready[1] and stage_ready[0] in the same cycle.
  - Response: next edge FAULT with fault_stage = 0, run = 0.
- Restart:
  - Stimulus: from FAULT, pulse restart for 3 cycles.
  - Response: state_dbg = 0 and fault = 0 on the first restart edge; stage_en[0] rises 16 edges after restart falls.
- Async reset mid-sequence:
  - Stimulus: assert rst_n low between clock edges while in STG1.
  - Response: all outputs 0 immediately without a clock edge; after release, full 16-cycle POR delay again.
